// File: rtl/m68k_bus_master_if.sv
// Host request/response signals plus 68000/6800 bus pins shared by the
// bus master (master modport) and whatever sits on the bus (slave modport).
interface m68k_bus_master_if;
  logic        req;
  logic        we;
  logic [22:0] addr;
  logic [1:0]  be;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        berr;
  logic        busy;
  logic [22:0] A;
  logic [15:0] D_out;
  logic [15:0] D_in;
  logic        D_oe;
  logic        nAS;
  logic        nUDS;
  logic        nLDS;
  logic        RW;
  logic        nDTACK;
  logic        nVPA;
  logic        E;
  logic        nVMA;
  logic        nBR;
  logic        nBG;
  logic        bus_oe;

  modport master (
    input  req, we, addr, be, wdata, D_in, nDTACK, nVPA, nBR,
    output rdata, ack, berr, busy, A, D_out, D_oe, nAS, nUDS, nLDS, RW,
           E, nVMA, nBG, bus_oe
  );

  modport slave (
    output req, we, addr, be, wdata, D_in, nDTACK, nVPA, nBR,
    input  rdata, ack, berr, busy, A, D_out, D_oe, nAS, nUDS, nLDS, RW,
           E, nVMA, nBG, bus_oe
  );
endinterface

// File: rtl/m68k_bus_master.sv
// 68000-style bus master: one half-state per C14M cycle, DTACK/VPA
// termination, wait-state timeout with bus error, and bus arbitration.
module m68k_bus_master #(
  parameter int TIMEOUT = 64
) (
  input logic              C14M_i,
  input logic              nRESET_i,
  m68k_bus_master_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, S0, S1, S2, S3, S4, S5, S6, S7, W, VWAIT, GRANT
  } state_e;

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [22:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;
  logic        vpa_q, vpa_d;
  logic        seen11_q, seen11_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic [4:0]  eCnt_q, eCnt_d;

  logic asAct;
  logic dsAct;
  logic rwLow;
  logic dataOe;
  logic granted;

  always_ff @(posedge C14M_i or negedge nRESET_i) begin
    if (!nRESET_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= 2'b00;
      wdata_q   <= '0;
      rdata_q   <= '0;
      berr_q    <= 1'b0;
      vpa_q     <= 1'b0;
      seen11_q  <= 1'b0;
      waitCnt_q <= '0;
      eCnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      berr_q    <= berr_d;
      vpa_q     <= vpa_d;
      seen11_q  <= seen11_d;
      waitCnt_q <= waitCnt_d;
      eCnt_q    <= eCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    berr_d    = berr_q;
    vpa_d     = vpa_q;
    seen11_d  = seen11_q;
    waitCnt_d = waitCnt_q;
    eCnt_d    = (eCnt_q == 5'd19) ? 5'd0 : eCnt_q + 5'd1;

    case (state_q)
      IDLE: begin
        if (!bus.nBR) begin
          state_d = GRANT;
        end else if (bus.req) begin
          addr_d  = bus.addr;
          we_d    = bus.we;
          be_d    = (bus.be == 2'b00) ? 2'b11 : bus.be;
          wdata_d = bus.wdata;
          state_d = S0;
        end
      end
      S0: begin
        waitCnt_d = '0;
        berr_d    = 1'b0;
        vpa_d     = 1'b0;
        seen11_d  = 1'b0;
        state_d   = S1;
      end
      S1: state_d = S2;
      S2: state_d = S3;
      S3: state_d = S4;
      // DTACK has priority over VPA; otherwise wait states come in S4/W pairs
      S4, W: begin
        waitCnt_d = waitCnt_q + 8'd1;
        if (!bus.nDTACK) begin
          state_d = S5;
        end else if (!bus.nVPA) begin
          state_d = VWAIT;
          vpa_d   = 1'b1;
        end else if (waitCnt_d == TimeoutLim) begin
          state_d = S5;
          berr_d  = 1'b1;
          rdata_d = 16'hFFFF;
        end else begin
          state_d = (state_q == S4) ? W : S4;
        end
      end
      // Sync to E: a count-11 cycle with VMA asserted must precede the count-19 transfer
      VWAIT: begin
        if (eCnt_q == 5'd11) seen11_d = 1'b1;
        if (seen11_q && eCnt_q == 5'd19) begin
          rdata_d = bus.D_in;
          state_d = S5;
        end
      end
      S5: state_d = S6;
      S6: begin
        if (!we_q && !vpa_q && !berr_q) rdata_d = bus.D_in;
        state_d = S7;
      end
      S7: state_d = bus.nBR ? IDLE : GRANT;
      GRANT: if (bus.nBR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    asAct  = (state_q inside {S2, S3, S4, S5, S6, W, VWAIT});
    dsAct  = we_q ? (state_q inside {S4, S5, S6, W, VWAIT}) : asAct;
    rwLow  = we_q && (state_q inside {S2, S3, S4, S5, S6, S7, W, VWAIT});
    dataOe = we_q && (state_q inside {S3, S4, S5, S6, S7, W, VWAIT});
    granted = (state_q == GRANT) && !bus.nBR;
  end

  assign bus.A      = addr_q;
  assign bus.D_out  = wdata_q;
  assign bus.D_oe   = dataOe;
  assign bus.nAS    = !asAct;
  assign bus.nUDS   = !(dsAct && be_q[1]);
  assign bus.nLDS   = !(dsAct && be_q[0]);
  assign bus.RW     = !rwLow;
  assign bus.rdata  = rdata_q;
  assign bus.ack    = (state_q == S7);
  assign bus.berr   = (state_q == S7) && berr_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.E      = (eCnt_q >= 5'd12);
  assign bus.nVMA   = !((state_q == VWAIT) || (vpa_q && (state_q inside {S5, S6})));
  assign bus.nBG    = !granted;
  assign bus.bus_oe = !granted;

endmodule
